// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: evaluates branch/jump outcome, checks the fetch
// prediction, issues a one-cycle redirect/flush and masks the wrong-path shadow.
module branch_resolve #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic             i_stall,
  input  logic             i_is_br,
  input  logic             i_is_jal,
  input  logic             i_is_jalr,
  input  logic [2:0]       i_funct3,
  input  logic             i_eq,
  input  logic             i_lt,
  input  logic             i_ltu,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic             i_pred_taken,
  input  logic [XLEN-1:0]  i_pred_target,
  output logic             o_redirect,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_flush,
  output logic             o_taken,
  output logic [XLEN-1:0]  o_link,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mis_cnt
);

  // state  | meaning
  // RUN    | accepting control-flow instructions
  // SHADOW | wrong-path instructions after a redirect are ignored; shd_cnt counts down
  typedef enum logic {RUN = 1'b0, SHADOW = 1'b1} state_t;

  localparam logic [XLEN-1:0]  ALIGN_MASK = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [1:0]        shd_cnt_q, shd_cnt_d;
  logic              redirect_q, redirect_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              taken_q, taken_d;
  logic [XLEN-1:0]   link_q, link_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  mis_cnt_q, mis_cnt_d;

  logic              cond;
  logic              taken;
  logic              accept;
  logic              mispredict;
  logic [XLEN-1:0]   target;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   next_pc;

  always_comb begin
    cond = 1'b0;
    case (i_funct3)
      3'b000:  cond = i_eq;
      3'b001:  cond = !i_eq;
      3'b100:  cond = i_lt;
      3'b101:  cond = !i_lt;
      3'b110:  cond = i_ltu;
      3'b111:  cond = !i_ltu;
      default: cond = 1'b0;
    endcase

    // JALR outranks JAL outranks BR when several type flags are set
    taken    = i_is_jalr | i_is_jal | (i_is_br & cond);
    target   = i_is_jalr ? ((i_rs1 + i_imm) & ALIGN_MASK) : (i_pc + i_imm);
    pc_plus4 = i_pc + XLEN'(4);
    next_pc  = taken ? target : pc_plus4;

    mispredict = (taken != i_pred_taken) || (taken && (target != i_pred_target));
    accept     = i_valid && !i_stall && (state_q == RUN) &&
                 (i_is_br | i_is_jal | i_is_jalr);

    state_d       = state_q;
    shd_cnt_d     = shd_cnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    taken_d       = taken_q;
    link_d        = link_q;
    br_cnt_d      = br_cnt_q;
    mis_cnt_d     = mis_cnt_q;

    if (accept) begin
      taken_d       = taken;
      link_d        = pc_plus4;
      redirect_pc_d = next_pc;
      if (br_cnt_q != CNT_MAX) br_cnt_d = br_cnt_q + CNT_W'(1);
      if (mispredict) begin
        redirect_d = 1'b1;
        state_d    = SHADOW;
        shd_cnt_d  = 2'd2;
        if (mis_cnt_q != CNT_MAX) mis_cnt_d = mis_cnt_q + CNT_W'(1);
      end
    end else if (state_q == SHADOW && !i_stall) begin
      shd_cnt_d = shd_cnt_q - 2'd1;
      if (shd_cnt_q <= 2'd1) begin
        state_d   = RUN;
        shd_cnt_d = 2'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      shd_cnt_q     <= 2'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      taken_q       <= 1'b0;
      link_q        <= '0;
      br_cnt_q      <= '0;
      mis_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      shd_cnt_q     <= shd_cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      taken_q       <= taken_d;
      link_q        <= link_d;
      br_cnt_q      <= br_cnt_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign o_redirect    = redirect_q;
  assign o_flush       = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_taken       = taken_q;
  assign o_link        = link_q;
  assign o_br_cnt      = br_cnt_q;
  assign o_mis_cnt     = mis_cnt_q;

endmodule
